fmul_pipe: RTL and testbench

- Pipelined, parametrised IEEE-754 single-precision multiplier for the FPU.
- Next generation of the combinational multiplier. Adds:
  - a valid/ready handshake and configurable latency;
  - selectable round-to-nearest-even (RNE) or truncation;
  - an explicit underflow flag;
  - special-value handling (zero, inf, NaN).
- Sits between FPU issue logic and the FPU writeback mux.

---
 rtl/fpu_pkg.sv | 51 +++++
 rtl/fmul_round_pack.sv | 64 ++++++
 rtl/fmul_pipe.sv | 140 ++++++++++++++
 tb/tb_fmul_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision types, constants and the
// operand-unpack helper used by the FPU multiplier.
package fpu_pkg;

  localparam int          FP_EXP_BIAS = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  // Payload carried between the product stage and the normalise/round stage.
  // The class bits are raw; their priority is resolved at pack time.
  typedef struct packed {
    logic              s;        // result sign
    logic signed [9:0] e;        // e1 + e2 - bias, before the normalise shift
    logic [47:0]       p;        // 24x24 significand product
    logic              is_nan;   // NaN operand, or zero times infinity
    logic              is_inf;   // at least one infinite operand
    logic              is_zero;  // at least one operand with e=0
  } fmul_stage_t;

  // Unpack both operands, form the full significand product and the biased
  // exponent sum. Subnormal operands are treated as zero everywhere,
  // including in the zero-times-infinity test.
  function automatic fmul_stage_t fmul_unpack(input fp32_t a, input fp32_t b);
    fmul_stage_t r;
    logic [47:0] sig_a;
    logic [47:0] sig_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a.e == FP_EXP_MAX) && (a.m != 23'd0);
    b_nan  = (b.e == FP_EXP_MAX) && (b.m != 23'd0);
    a_inf  = (a.e == FP_EXP_MAX) && (a.m == 23'd0);
    b_inf  = (b.e == FP_EXP_MAX) && (b.m == 23'd0);
    a_zero = (a.e == 8'd0);
    b_zero = (b.e == 8'd0);
    sig_a  = {24'd0, 1'b1, a.m};
    sig_b  = {24'd0, 1'b1, b.m};
    r.s       = a.s ^ b.s;
    r.e       = $signed({2'b00, a.e}) + $signed({2'b00, b.e}) - $signed(10'(FP_EXP_BIAS));
    r.p       = sig_a * sig_b;
    r.is_nan  = a_nan | b_nan | (a_zero & b_inf) | (b_zero & a_inf);
    r.is_inf  = a_inf | b_inf;
    r.is_zero = a_zero | b_zero;
    return r;
  endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// fmul_round_pack: combinational normalise, round and special-case pack for
// the final multiplier stage.
module fmul_round_pack
  import fpu_pkg::*;
#(
  parameter bit ROUND_RNE = 1'b1   // 1 = round to nearest even, 0 = truncate
) (
  input  logic              s,
  input  logic signed [9:0] e,
  input  logic [47:0]       p,
  input  logic              is_nan,
  input  logic              is_inf,
  input  logic              is_zero,
  output logic [31:0]       y,
  output logic              ovf,
  output logic              udf
);

  logic              n;
  logic [22:0]       mant;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [23:0]       mant_r;
  logic [22:0]       mant_f;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;

  // Normalise on the product MSB, then round; a rounding carry-out bumps the exponent.
  always_comb begin
    n      = p[47];
    mant   = n ? p[46:24] : p[45:23];
    guard  = n ? p[23] : p[22];
    sticky = n ? (|p[22:0]) : (|p[21:0]);
    inc    = ROUND_RNE && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {23'd0, inc};
    e_n    = e + $signed({9'd0, n});
    e_r    = e_n + $signed({9'd0, mant_r[23]});
    mant_f = mant_r[23] ? 23'd0 : mant_r[22:0];
  end

  // Special cases in priority order; ovf and udf are mutually exclusive by construction.
  always_comb begin
    y   = 32'd0;
    ovf = 1'b0;
    udf = 1'b0;
    if (is_nan) begin
      y = FP_QNAN;
    end else if (is_inf) begin
      y = {s, FP_EXP_MAX, 23'd0};
    end else if (is_zero) begin
      y = {s, 31'd0};
    end else if (e_r >= 10'sd255) begin
      y   = {s, FP_EXP_MAX, 23'd0};
      ovf = 1'b1;
    end else if (e_r <= 10'sd0) begin
      y   = {s, 31'd0};
      udf = 1'b1;
    end else begin
      y = {s, e_r[7:0], mant_f};
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined single-precision multiplier with a valid/ready
// handshake. STAGES (1..3) registers sit between accept and out_valid; the
// whole pipe advances together and freezes while the output is stalled.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int STAGES    = 2,     // latency in cycles, legal 1..3
  parameter bit ROUND_RNE = 1'b1   // 1 = round to nearest even, 0 = truncate
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  logic        stall;
  fmul_stage_t st_in;
  fmul_stage_t st_fin;
  logic        fin_valid;
  logic [31:0] rp_y;
  logic        rp_ovf;
  logic        rp_udf;

  logic        out_valid_q, out_valid_d;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Stage-1 work: unpack, product, exponent sum.
  always_comb begin
    st_in = fmul_unpack(x1, x2);
  end

  generate
    if (STAGES > 1) begin : g_pl
      fmul_stage_t pl_q    [STAGES-1];
      fmul_stage_t pl_d    [STAGES-1];
      fmul_stage_t pl_src  [STAGES-1];
      logic        vld_q   [STAGES-1];
      logic        vld_d   [STAGES-1];
      logic        vld_src [STAGES-1];

      for (genvar gi = 0; gi < STAGES-1; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign pl_src[gi]  = st_in;
          assign vld_src[gi] = in_valid;
        end else begin : g_tail
          assign pl_src[gi]  = pl_q[gi-1];
          assign vld_src[gi] = vld_q[gi-1];
        end

        // Take the upstream slot (bubbles included) unless the output is stalled.
        always_comb begin
          pl_d[gi]  = pl_q[gi];
          vld_d[gi] = vld_q[gi];
          if (!stall) begin
            pl_d[gi]  = pl_src[gi];
            vld_d[gi] = vld_src[gi];
          end
        end

        // Payload register; reset drops whatever was in flight.
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            pl_q[gi]  <= '0;
            vld_q[gi] <= 1'b0;
          end else begin
            pl_q[gi]  <= pl_d[gi];
            vld_q[gi] <= vld_d[gi];
          end
        end
      end

      assign st_fin    = pl_q[STAGES-2];
      assign fin_valid = vld_q[STAGES-2];
    end else begin : g_flat
      assign st_fin    = st_in;
      assign fin_valid = in_valid;
    end
  endgenerate

  fmul_round_pack #(
    .ROUND_RNE (ROUND_RNE)
  ) u_round_pack (
    .s       (st_fin.s),
    .e       (st_fin.e),
    .p       (st_fin.p),
    .is_nan  (st_fin.is_nan),
    .is_inf  (st_fin.is_inf),
    .is_zero (st_fin.is_zero),
    .y       (rp_y),
    .ovf     (rp_ovf),
    .udf     (rp_udf)
  );

  // Output register: loads every non-stalled cycle (bubbles load zeros), holds while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (!stall) begin
      out_valid_d = fin_valid;
      y_d         = fin_valid ? rp_y : 32'd0;
      ovf_d       = fin_valid & rp_ovf;
      udf_d       = fin_valid & rp_udf;
    end
  end

  // Output flops, cleared asynchronously so nothing surfaces after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: randomized and directed bench for fmul_pipe. Two instances
// share the operand stream: u_dut (2 stages, RNE, driven out_ready) and
// u_trunc (3 stages, truncate, always ready). Each has its own scoreboard
// filled from an arithmetic reference model on every input transfer.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x1, x2;
  logic        out_ready_a, out_ready_b;
  logic        a_in_ready, a_out_valid, a_ovf, a_udf;
  logic [31:0] a_y;
  logic        b_in_ready, b_out_valid, b_ovf, b_udf;
  logic [31:0] b_y;

  always #5 clk = ~clk;

  fmul_pipe #(.STAGES(2), .ROUND_RNE(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready),
    .x1(x1), .x2(x2), .out_valid(a_out_valid), .out_ready(out_ready_a),
    .y(a_y), .ovf(a_ovf), .udf(a_udf)
  );

  fmul_pipe #(.STAGES(3), .ROUND_RNE(1'b0)) u_trunc (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(b_in_ready),
    .x1(x1), .x2(x2), .out_valid(b_out_valid), .out_ready(out_ready_b),
    .y(b_y), .ovf(b_ovf), .udf(b_udf)
  );

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic        udf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int a_done   = 0;
  int stall_cnt = 0;
  int rdy_mode = 0;   // 0: ready, 1: random, 2: held low
  bit lat_mode = 1'b1;
  bit ovr = 1'b0;
  logic [31:0] ovr_ya, ovr_yb;
  logic ovr_ovf, ovr_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: exact integer product, normalise by magnitude, round by comparing the remainder to half an ulp.
  function automatic void fmul_model(input logic [31:0] a, input logic [31:0] b, input bit rne,
                                     output logic [31:0] y, output logic ovf, output logic udf);
    int ea, eb, e, sh;
    longint unsigned p, kept, rem, half;
    logic s;
    bit nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    s     = a[31] ^ b[31];
    ea    = int'(a[30:23]);
    eb    = int'(b[30:23]);
    nan_a = (ea == 255) && (a[22:0] != 0);
    nan_b = (eb == 255) && (b[22:0] != 0);
    inf_a = (ea == 255) && (a[22:0] == 0);
    inf_b = (eb == 255) && (b[22:0] == 0);
    zer_a = (ea == 0);
    zer_b = (eb == 0);
    y = 32'd0; ovf = 1'b0; udf = 1'b0;
    if (nan_a || nan_b || (zer_a && inf_b) || (zer_b && inf_a)) y = 32'h7FC00000;
    else if (inf_a || inf_b) y = {s, 8'hFF, 23'd0};
    else if (zer_a || zer_b) y = {s, 31'd0};
    else begin
      p    = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      e    = ea + eb - 127;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = e + sh - 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      if (rne && ((rem > half) || ((rem == half) && kept[0]))) kept = kept + 1;
      if (kept == (64'd1 << 24)) begin kept = kept >> 1; e = e + 1; end
      if (e >= 255) begin y = {s, 8'hFF, 23'd0}; ovf = 1'b1; end
      else if (e <= 0) begin y = {s, 31'd0}; udf = 1'b1; end
      else y = {s, e[7:0], kept[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       r[30:0]  = 31'd0;
      1:       r[30:0]  = {8'hFF, 23'd0};
      2:       begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3:       r[30:23] = 8'd0;
      4, 5:    r[30:23] = 8'($urandom_range(1, 254));
      6:       r[30:23] = 8'($urandom_range(1, 20));
      7:       r[30:23] = 8'($urandom_range(235, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready for the main instance follows the current mode
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready_a = 1'b1;
      1:       out_ready_a = ($urandom_range(0, 3) != 0);
      default: out_ready_a = 1'b0;
    endcase
  end

  // Scoreboard for u_dut
  always @(negedge clk) begin
    exp_t ent;
    if (rstn) begin
      if (a_out_valid && !out_ready_a) begin
        stall_cnt++;
        check("a_in_ready_stall", {31'd0, a_in_ready}, 32'd0);
        if (q_a.size() > 0) check("a_y_stable", a_y, q_a[0].y);
      end
      if (a_out_valid && out_ready_a) begin
        if (q_a.size() == 0) check("a_spurious_out", 32'd1, 32'd0);
        else begin
          ent = q_a.pop_front();
          a_done++;
          $display("a: y=%08h ovf=%0d udf=%0d exp=%08h", a_y, a_ovf, a_udf, ent.y);
          check("a_y", a_y, ent.y);
          check("a_ovf", {31'd0, a_ovf}, {31'd0, ent.ovf});
          check("a_udf", {31'd0, a_udf}, {31'd0, ent.udf});
          check("a_excl", {31'd0, a_ovf & a_udf}, 32'd0);
          if (ent.lat) check("a_latency", cyc - ent.cyc, 32'd2);
        end
      end
      if (in_valid && a_in_ready) begin
        ent.cyc = cyc;
        ent.lat = lat_mode;
        if (ovr) begin ent.y = ovr_ya; ent.ovf = ovr_ovf; ent.udf = ovr_udf; end
        else fmul_model(x1, x2, 1'b1, ent.y, ent.ovf, ent.udf);
        q_a.push_back(ent);
      end
    end
  end

  // Scoreboard for u_trunc (never back-pressured)
  always @(negedge clk) begin
    exp_t ent;
    if (rstn) begin
      if (b_out_valid) begin
        if (q_b.size() == 0) check("b_spurious_out", 32'd1, 32'd0);
        else begin
          ent = q_b.pop_front();
          $display("b: y=%08h ovf=%0d udf=%0d exp=%08h", b_y, b_ovf, b_udf, ent.y);
          check("b_y", b_y, ent.y);
          check("b_ovf", {31'd0, b_ovf}, {31'd0, ent.ovf});
          check("b_udf", {31'd0, b_udf}, {31'd0, ent.udf});
          check("b_latency", cyc - ent.cyc, 32'd3);
        end
      end
      if (in_valid && b_in_ready) begin
        ent.cyc = cyc;
        ent.lat = 1'b1;
        if (ovr) begin ent.y = ovr_yb; ent.ovf = ovr_ovf; ent.udf = ovr_udf; end
        else fmul_model(x1, x2, 1'b0, ent.y, ent.ovf, ent.udf);
        q_b.push_back(ent);
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one operand pair until u_dut accepts it (bounded wait).
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; x1 = a; x2 = b;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_ovr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ya,
                          input logic [31:0] yb, input logic ov, input logic ud);
    ovr = 1'b1; ovr_ya = ya; ovr_yb = yb; ovr_ovf = ov; ovr_udf = ud;
    send(a, b);
    ovr = 1'b0;
  endtask

  logic [31:0] d_x1  [7] = '{32'h40000000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
                             32'h80000000, 32'h3FC00000, 32'hC0000000};
  logic [31:0] d_x2  [7] = '{32'h40400000, 32'h3FC00001, 32'h7F000000, 32'h3F000000,
                             32'h7F800000, 32'h3FC00000, 32'h3F800000};
  logic [31:0] d_yr  [7] = '{32'h40C00000, 32'h40100002, 32'h7F800000, 32'h00000000,
                             32'h7FC00000, 32'h40100000, 32'hC0000000};
  logic [31:0] d_yt  [7] = '{32'h40C00000, 32'h40100001, 32'h7F800000, 32'h00000000,
                             32'h7FC00000, 32'h40100000, 32'hC0000000};
  logic        d_ovf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        d_udf [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int a_base;
    rstn = 1'b0; in_valid = 1'b0; x1 = 32'd0; x2 = 32'd0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    ovr_ya = 32'd0; ovr_yb = 32'd0; ovr_ovf = 1'b0; ovr_udf = 1'b0;

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_a_y", a_y, 32'd0);
    check("rst_a_ovf", {31'd0, a_ovf}, 32'd0);
    check("rst_a_udf", {31'd0, a_udf}, 32'd0);
    check("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("rst_b_y", b_y, 32'd0);
    rstn = 1'b1;
    idle(2);

    // directed vectors, back to back, always ready
    for (int i = 0; i < 7; i++) send_ovr(d_x1[i], d_x2[i], d_yr[i], d_yt[i], d_ovf[i], d_udf[i]);
    idle(6);

    // backpressure: 5 back-to-back ops with out_ready held low for 3 cycles
    lat_mode = 1'b0; a_base = a_done; stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(rand_op(), rand_op());
      end
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(8);
    check("bp_delivered", a_done - a_base, 32'd5);
    check("bp_stall_cycles", stall_cnt, 32'd3);

    // randomized stream with random backpressure and bubbles
    rdy_mode = 1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      send(rand_op(), rand_op());
    end
    idle(1);
    rdy_mode = 0;
    idle(10);

    // reset while two operations are in flight
    lat_mode = 1'b1;
    send(32'h40000000, 32'h40400000);
    send(32'h3F800000, 32'h40000000);
    rstn = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    check("mid_rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("mid_rst_a_y", a_y, 32'd0);
    check("mid_rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("mid_rst_b_y", b_y, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_a_idle", {31'd0, a_out_valid}, 32'd0);
      check("post_rst_b_idle", {31'd0, b_out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send_ovr(32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 1'b0, 1'b0);
    idle(8);

    check("a_queue_empty", q_a.size(), 32'd0);
    check("b_queue_empty", q_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
